// File: rtl/ps2_pkg.sv
// Shared PS/2 host definitions: transmit state encoding, 50 MHz timing defaults,
// frame geometry and the odd-parity helper.
package ps2_pkg;

    localparam int PS2_INHIBIT_CYCLES_50M = 5000;
    localparam int PS2_TIMEOUT_CYCLES_50M = 750000;
    localparam int PS2_FRAME_LEN          = 11;
    localparam int PS2_DATA_BITS          = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a one-cycle
// pulse on each synchronized falling edge of the clock line.
module ps2_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic i_clk_raw,
    input  logic i_data_raw,
    output logic o_clk,
    output logic o_data,
    output logic o_clk_fall
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;

    // Idle PS/2 lines float high, so every flop comes out of reset at 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_clk_raw};
            r_data_sync <= {r_data_sync[0], i_data_raw};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign o_clk      = r_clk_sync[1];
    assign o_data     = r_data_sync[1];
    assign o_clk_fall = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift 8 data
// bits + odd parity + stop on device clock edges, then check the device ack.
// Board wiring per line: pad = oe ? 1'b0 : 1'bz; busy gates the receiver.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | lines released, tx_ready high, waiting for tx_valid
// ST_INHIBIT   | clock held low INHIBIT_CYCLES; data pulled low in last cycle
// ST_START     | clock released, data low (start bit), timeout armed
// ST_SHIFT     | drive data/parity/stop on device falling edges 1..10
// ST_ACK       | sample device ack on falling edge 11
// ST_WAIT_IDLE | wait for both lines high, then report done
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_50M,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_50M
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    // Bit counter holds (edge number - 1) when an edge arrives.
    localparam logic [3:0] PARITY_IDX = 4'(PS2_DATA_BITS);
    localparam logic [3:0] STOP_IDX   = 4'(PS2_FRAME_LEN - 2);

    ps2_tx_state_e    r_state, w_state_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_parity, w_parity_nxt;
    logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_nxt;
    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
    logic             r_data_oe, w_data_oe_nxt;

    logic w_clk_lvl;
    logic w_data_lvl;
    logic w_clk_fall;

    ps2_edge_sync u_sync (
        .clock      (clock),
        .reset      (reset),
        .i_clk_raw  (ps2_clk_in),
        .i_data_raw (ps2_data_in),
        .o_clk      (w_clk_lvl),
        .o_data     (w_data_lvl),
        .o_clk_fall (w_clk_fall)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_tmo_cnt <= '0;
            r_data_oe <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_data    <= w_data_nxt;
            r_parity  <= w_parity_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_inh_cnt <= w_inh_cnt_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_data_oe <= w_data_oe_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = r_data;
        w_parity_nxt  = r_parity;
        w_bit_cnt_nxt = r_bit_cnt;
        w_inh_cnt_nxt = r_inh_cnt;
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_data_oe_nxt = r_data_oe;
        tx_ready      = 1'b0;
        busy          = 1'b1;
        ps2_clk_oe    = 1'b0;
        ps2_data_oe   = 1'b0;
        tx_done       = 1'b0;
        tx_error      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid) begin
                    w_data_nxt    = tx_data;
                    w_parity_nxt  = ps2_odd_parity(tx_data);
                    w_bit_cnt_nxt = '0;
                    w_inh_cnt_nxt = INH_LOAD;
                    w_state_nxt   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (r_inh_cnt == '0) begin
                    ps2_data_oe = 1'b1;
                    w_state_nxt = ST_START;
                end else begin
                    w_inh_cnt_nxt = r_inh_cnt - 1'b1;
                end
            end
            ST_START: begin
                ps2_data_oe   = 1'b1;
                w_data_oe_nxt = 1'b1;
                w_tmo_cnt_nxt = TMO_LOAD;
                w_state_nxt   = ST_SHIFT;
            end
            ST_SHIFT: begin
                ps2_data_oe = r_data_oe;
                if (w_clk_fall) begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt < PARITY_IDX) begin
                        w_data_oe_nxt = ~r_data[r_bit_cnt[2:0]];
                    end else if (r_bit_cnt < STOP_IDX) begin
                        w_data_oe_nxt = ~r_parity;
                    end else begin
                        w_data_oe_nxt = 1'b0;
                        w_state_nxt   = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (w_clk_fall) begin
                    if (!w_data_lvl) begin
                        w_state_nxt = ST_WAIT_IDLE;
                    end else begin
                        tx_error    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (w_clk_lvl && w_data_lvl) begin
                    tx_done     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Timeout overrides whatever the frame logic decided this cycle.
        if (r_state inside {ST_SHIFT, ST_ACK, ST_WAIT_IDLE}) begin
            if (r_tmo_cnt == '0) begin
                tx_error      = 1'b1;
                tx_done       = 1'b0;
                ps2_clk_oe    = 1'b0;
                ps2_data_oe   = 1'b0;
                w_data_oe_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end else begin
                w_tmo_cnt_nxt = r_tmo_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: table of command bytes against a device model
// that clocks the frame and acks, plus timeout and mid-frame reset sequences.
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TMO = 2000;

    logic       clock = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_done;
    logic       tx_error;
    logic       busy;
    logic       dev_clk;
    logic       dev_data;

    // Open-collector lines: either side may pull low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    int n_done  = 0;
    int n_err   = 0;
    logic prev_err = 1'b0;

    logic [9:0] frame;
    int         inh_len;
    int         inh_dcyc;
    logic       inh_last;
    logic       start_ok;
    int         tmo_cycles;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         junk;
        logic [9:0] exp_frame;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    always @(negedge clock) begin
        if (prev_err)
            check("ready_after_err", 32'({tx_ready, ps2_clk_oe, ps2_data_oe}), 32'b100);
        if (tx_done || tx_error) begin
            check("release_on_exit", 32'({ps2_clk_oe, ps2_data_oe}), 0);
            check("done_err_excl", 32'(tx_done & tx_error), 0);
        end
        if (tx_done) n_done++;
        if (tx_error) n_err++;
        prev_err = tx_error;
    end

    // mode 0: normal frame, 1: device never clocks, 2: reset after edge 5
    task automatic run_frame(input logic [7:0] d, input bit ack, input bit junk, input int mode);
        frame    = '0;
        inh_len  = 0;
        inh_dcyc = 0;
        inh_last = 1'b0;
        @(negedge clock);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clock);
        if (junk) tx_data = 8'h55;
        else tx_valid = 1'b0;
        while (ps2_clk_oe && inh_len < 500) begin
            inh_len++;
            if (ps2_data_oe) inh_dcyc++;
            inh_last = ps2_data_oe;
            @(negedge clock);
        end
        tx_valid = 1'b0;
        start_ok = !ps2_clk_oe && ps2_data_oe;
        if (mode == 1) begin
            tmo_cycles = 0;
            while (!tx_error && tmo_cycles < 3000) begin
                @(negedge clock);
                tmo_cycles++;
            end
            repeat (5) @(negedge clock);
            return;
        end
        repeat (5) @(negedge clock);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) begin
                if (ack) dev_data = 1'b0;
                repeat (3) @(negedge clock);
            end
            dev_clk = 1'b0;
            repeat (10) @(negedge clock);
            if (i <= 10) frame[i-1] = ps2_data_in;
            if (mode == 2 && i == 5) begin
                check("oe_before_reset", 32'(ps2_data_oe), 1);
                #2 reset = 1'b1;
                #1;
                check("rst_mid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
                check("rst_mid_ready", 32'({tx_ready, busy}), 32'b10);
                @(negedge clock);
                reset    = 1'b0;
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                repeat (5) @(negedge clock);
                return;
            end
            dev_clk = 1'b1;
            repeat (10) @(negedge clock);
        end
        dev_data = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    initial begin
        int d0;
        int e0;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        check("rst_pulses", 32'({tx_done, tx_error}), 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // frame = {stop, parity, data[7:0]} as seen on the line, LSB first
        vecs[0] = '{data: 8'hED, ack: 1'b1, junk: 1'b0, exp_frame: 10'h3ED, exp_done: 1, exp_err: 0};
        vecs[1] = '{data: 8'h07, ack: 1'b1, junk: 1'b0, exp_frame: 10'h207, exp_done: 1, exp_err: 0};
        vecs[2] = '{data: 8'h00, ack: 1'b1, junk: 1'b0, exp_frame: 10'h300, exp_done: 1, exp_err: 0};
        vecs[3] = '{data: 8'hED, ack: 1'b0, junk: 1'b0, exp_frame: 10'h3ED, exp_done: 0, exp_err: 1};
        vecs[4] = '{data: 8'hA5, ack: 1'b1, junk: 1'b1, exp_frame: 10'h3A5, exp_done: 1, exp_err: 0};

        for (int v = 0; v < 5; v++) begin
            d0 = n_done;
            e0 = n_err;
            run_frame(vecs[v].data, vecs[v].ack, vecs[v].junk, 0);
            check($sformatf("inhibit_len[%0d]", v), 32'(inh_len), INH);
            check($sformatf("inhibit_data_cycles[%0d]", v), 32'(inh_dcyc), 1);
            check($sformatf("inhibit_data_last[%0d]", v), 32'(inh_last), 1);
            check($sformatf("start_bit[%0d]", v), 32'(start_ok), 1);
            check($sformatf("frame[%0d]", v), 32'(frame), 32'(vecs[v].exp_frame));
            check($sformatf("done_count[%0d]", v), 32'(n_done - d0), 32'(vecs[v].exp_done));
            check($sformatf("err_count[%0d]", v), 32'(n_err - e0), 32'(vecs[v].exp_err));
            repeat (5) @(negedge clock);
            check($sformatf("idle_after[%0d]", v), 32'({tx_ready, busy}), 32'b10);
        end

        d0 = n_done;
        e0 = n_err;
        run_frame(8'h12, 1'b1, 1'b0, 1);
        check("tmo_start_bit", 32'(start_ok), 1);
        check("tmo_cycles", 32'(tmo_cycles), TMO);
        check("tmo_err_count", 32'(n_err - e0), 1);
        check("tmo_done_count", 32'(n_done - d0), 0);
        check("tmo_idle", 32'({tx_ready, busy, ps2_clk_oe, ps2_data_oe}), 32'b1000);

        d0 = n_done;
        e0 = n_err;
        run_frame(8'hED, 1'b1, 1'b0, 2);
        check("rst_no_pulses", 32'((n_done - d0) + (n_err - e0)), 0);
        d0 = n_done;
        run_frame(8'hF4, 1'b1, 1'b0, 0);
        check("f4_frame", 32'(frame), 32'h2F4);
        check("f4_done", 32'(n_done - d0), 1);
        check("f4_inhibit_len", 32'(inh_len), INH);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
